// File: rtl/cond_pkg.sv
// Shared condition-code encodings and flag bit positions for the execute-stage condition unit.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Q = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against the stored N,Z,C,V flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N-1];
  assign z = nzcv[FLAG_Z-1];
  assign c = nzcv[FLAG_C-1];
  assign v = nzcv[FLAG_V-1];

  always_comb begin
    pass = 1'b0;
    unique case (CondE)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: architectural flag register, update priority and output gating.
// Sticky Q flag storage exists only when COND_QFLAG_EN is defined; otherwise Flags[0] reads 0.
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [4:0] RESET_FLAGS = 5'b00000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic       ValidE,
  input  logic [3:0] CondE,
  input  logic [4:0] ALUFlags,
  input  logic [1:0] FlagWriteE,
  input  logic       QWriteE,
  input  logic       FlagLoadE,
  input  logic [4:0] FlagLoadData,
  input  logic       PCSE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       BranchE,
  output logic       CondExE,
  output logic       PCSrcE,
  output logic       RegWriteGE,
  output logic       MemWriteGE,
  output logic [4:0] Flags
);

  logic       live;
  logic       pass;
  logic [3:0] nzcv_q, nzcv_d;

  // live already excludes stall, so a stalled cycle can neither load nor update flags
  assign live = ValidE & ~flush & ~stall;

  cond_check u_cond_check (
    .CondE (CondE),
    .nzcv  (nzcv_q),
    .pass  (pass)
  );

  assign CondExE    = live & pass;
  assign PCSrcE     = (PCSE | BranchE) & CondExE;
  assign RegWriteGE = RegWriteE & CondExE;
  assign MemWriteGE = MemWriteE & CondExE;

  always_comb begin
    nzcv_d = nzcv_q;
    if (FlagLoadE && live) begin
      nzcv_d = FlagLoadData[FLAG_N:FLAG_V];
    end else if (CondExE) begin
      if (FlagWriteE[1]) nzcv_d[FLAG_N-1:FLAG_Z-1] = ALUFlags[FLAG_N:FLAG_Z];
      if (FlagWriteE[0]) nzcv_d[FLAG_C-1:FLAG_V-1] = ALUFlags[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) nzcv_q <= RESET_FLAGS[FLAG_N:FLAG_V];
    else       nzcv_q <= nzcv_d;
  end

`ifdef COND_QFLAG_EN
  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (FlagLoadE && live) q_d = FlagLoadData[FLAG_Q];
    else if (CondExE && QWriteE) q_d = q_q | ALUFlags[FLAG_Q];
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= RESET_FLAGS[FLAG_Q];
    else       q_q <= q_d;
  end

  assign Flags = {nzcv_q, q_q};
`else
  logic unused_q_inputs;
  assign unused_q_inputs = ^{QWriteE, ALUFlags[FLAG_Q], FlagLoadData[FLAG_Q]};
  assign Flags = {nzcv_q, 1'b0};
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit; Q expectations follow COND_QFLAG_EN.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset, stall, flush, ValidE;
  logic [3:0] CondE;
  logic [4:0] ALUFlags;
  logic [1:0] FlagWriteE;
  logic       QWriteE, FlagLoadE;
  logic [4:0] FlagLoadData;
  logic       PCSE, RegWriteE, MemWriteE, BranchE;
  logic       CondExE, PCSrcE, RegWriteGE, MemWriteGE;
  logic [4:0] Flags;

  int n_total = 0;
  int n_pass  = 0;

  cond_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ValidE(ValidE),
    .CondE(CondE), .ALUFlags(ALUFlags), .FlagWriteE(FlagWriteE), .QWriteE(QWriteE),
    .FlagLoadE(FlagLoadE), .FlagLoadData(FlagLoadData), .PCSE(PCSE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .CondExE(CondExE), .PCSrcE(PCSrcE), .RegWriteGE(RegWriteGE),
    .MemWriteGE(MemWriteGE), .Flags(Flags)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] qm(input logic [4:0] f);
`ifdef COND_QFLAG_EN
    return f;
`else
    return {f[4:1], 1'b0};
`endif
  endfunction

  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; ValidE = 1; CondE = 4'hE; ALUFlags = 0; FlagWriteE = 0;
    QWriteE = 0; FlagLoadE = 0; FlagLoadData = 0; PCSE = 0; RegWriteE = 0;
    MemWriteE = 0; BranchE = 0;
  endtask

  task automatic load_flags(input logic [4:0] v);
    idle_inputs();
    FlagLoadE = 1; FlagLoadData = v;
    tick();
    FlagLoadE = 0;
  endtask

  initial begin
    logic [4:0] lv [7];
    lv = '{5'b00000, 5'b01000, 5'b00100, 5'b10010, 5'b10000, 5'b00010, 5'b11110};

    idle_inputs();
    ValidE = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("reset_flags", Flags, 5'b00000);
    ValidE = 1; CondE = 4'h0; #1;
    chk("reset_eq", {4'b0, CondExE}, 5'd0);
    CondE = 4'hE; #1;
    chk("reset_al", {4'b0, CondExE}, 5'd1);

    // Z set through an AL instruction, visible to the next one
    CondE = 4'hE; ALUFlags = 5'b01000; FlagWriteE = 2'b11;
    tick();
    chk("z_update", Flags, 5'b01000);
    idle_inputs();
    CondE = 4'h0; RegWriteE = 1; #1;
    chk("eq_regwrite", {4'b0, RegWriteGE}, 5'd1);
    CondE = 4'h1; #1;
    chk("ne_regwrite", {4'b0, RegWriteGE}, 5'd0);

    // GE fails with N=1,V=0 so no update; LT passes and updates
    load_flags(5'b10000);
    chk("load_n", Flags, 5'b10000);
    CondE = 4'hA; FlagWriteE = 2'b11; ALUFlags = 5'b00110; #1;
    chk("ge_fail", {4'b0, CondExE}, 5'd0);
    tick();
    chk("ge_noupdate", Flags, 5'b10000);
    CondE = 4'hB; BranchE = 1; MemWriteE = 1; #1;
    chk("lt_pass", {2'b0, CondExE, PCSrcE, MemWriteGE}, 5'b00111);
    tick();
    chk("lt_update", Flags, 5'b00110);

    // sticky Q
    idle_inputs();
    QWriteE = 1; ALUFlags = 5'b00001;
    tick();
    chk("q_set", Flags, qm(5'b00111));
    ALUFlags = 5'b00000; FlagWriteE = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("q_sticky%0d", i), Flags, qm(5'b00001));
    end
    load_flags(5'b00000);
    chk("q_clear_load", Flags, 5'b00000);

    // stall blocks load and update, then flush does the same
    idle_inputs();
    stall = 1; FlagWriteE = 2'b11; ALUFlags = 5'b11110; QWriteE = 1;
    FlagLoadE = 1; FlagLoadData = 5'b11111;
    RegWriteE = 1; MemWriteE = 1; BranchE = 1; PCSE = 1; #1;
    chk("stall_outs", {1'b0, CondExE, PCSrcE, RegWriteGE, MemWriteGE}, 5'd0);
    tick();
    chk("stall_flags", Flags, 5'b00000);
    stall = 0; flush = 1; #1;
    chk("flush_outs", {1'b0, CondExE, PCSrcE, RegWriteGE, MemWriteGE}, 5'd0);
    tick();
    chk("flush_flags", Flags, 5'b00000);
    flush = 0; ValidE = 0; FlagLoadE = 0; #1;
    chk("invalid_outs", {1'b0, CondExE, PCSrcE, RegWriteGE, MemWriteGE}, 5'd0);
    tick();
    chk("invalid_flags", Flags, 5'b00000);

    // condition table sweep over several flag patterns
    for (int k = 0; k < 7; k++) begin
      load_flags(lv[k]);
      for (int c = 0; c < 16; c++) begin
        CondE = 4'(c); #1;
        chk($sformatf("cond_f%b_c%0d", lv[k][4:1], c), {4'b0, CondExE},
            {4'b0, model_pass(4'(c), lv[k][4:1])});
      end
    end

    // load beats same-cycle ALU write; reset then wins over a live update
    idle_inputs();
    FlagLoadE = 1; FlagLoadData = 5'b00101; FlagWriteE = 2'b11; ALUFlags = 5'b11000;
    tick();
    chk("load_priority", Flags, qm(5'b00101));
    FlagLoadE = 0; reset = 1; QWriteE = 1; ALUFlags = 5'b11111;
    tick();
    chk("reset_mid", Flags, 5'b00000);
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
